// File: rtl/irq_prio_ctrl.sv
// Priority interrupt controller: edge/level pending capture, per-line enable masking,
// lowest-index arbitration and a req/ack/done handshake towards the core trap logic.
module irq_prio_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [NUM_IRQ-1:0] irq_edge_i,
    input  logic               irq_ack_i,
    input  logic               irq_done_i,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_IRQ-1:0] irq_pending_o,
    output logic               irq_active_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] prev, pend, pend_next, rise, cand;
    logic [ID_W-1:0]    id, id_next, winner;
    logic               cand_hit, ack_take;

    assign rise     = irq_i & ~prev;
    assign cand     = pend & irq_en_i;
    assign ack_take = (state == REQ) && irq_ack_i;

    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
        winner   = '0;
        cand_hit = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ID_W'(i) == id) cand_hit = cand[i];
        end
    end

    // Edge lines: a rise in the ack cycle re-arms the bit, so set beats clear.
    always_comb begin
        pend_next = pend;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge_i[i])
                pend_next[i] = rise[i] | (pend[i] & ~(ack_take && (ID_W'(i) == id)));
            else
                pend_next[i] = irq_i[i];
        end
    end

    always_comb begin
        state_next = state;
        id_next    = id;
        unique case (state)
            IDLE: begin
                if (cand != '0) begin
                    state_next = REQ;
                    id_next    = winner;
                end
            end
            REQ: begin
                if (irq_ack_i)     state_next = SERVICE;
                else if (!cand_hit) state_next = IDLE;
            end
            SERVICE: begin
                if (irq_done_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (areset) begin
            state <= IDLE;
            id    <= '0;
            prev  <= '0;
            pend  <= '0;
        end else begin
            state <= state_next;
            id    <= id_next;
            prev  <= irq_i;
            pend  <= pend_next;
        end
    end

    assign irq_req_o     = (state == REQ);
    assign irq_active_o  = (state == SERVICE);
    assign irq_id_o      = id;
    assign irq_pending_o = pend;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed self-checking bench for irq_prio_ctrl; expected values are hand-derived
// from the intended cycle behaviour and checked with immediate assertions.
module tb_irq_prio_ctrl;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    logic               aclk = 1'b0;
    logic               areset;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_en;
    logic [NUM_IRQ-1:0] irq_edge;
    logic               irq_ack;
    logic               irq_done;
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               irq_active;

    int total = 0;
    int bad   = 0;

    irq_prio_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .irq_i         (irq),
        .irq_en_i      (irq_en),
        .irq_edge_i    (irq_edge),
        .irq_ack_i     (irq_ack),
        .irq_done_i    (irq_done),
        .irq_req_o     (irq_req),
        .irq_id_o      (irq_id),
        .irq_pending_o (irq_pending),
        .irq_active_o  (irq_active)
    );

    always #5 aclk = ~aclk;

    // One rising edge, then settle away from the edge before checking or driving.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_req(input string tag, input logic req_exp, input logic [ID_W-1:0] id_exp);
        check({tag, "_req"}, 32'(irq_req), 32'(req_exp));
        if (req_exp) check({tag, "_id"}, 32'(irq_id), 32'(id_exp));
    endtask

    initial begin
        areset   = 1'b1;
        irq      = '0;
        irq_en   = '0;
        irq_edge = '0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        tick(2);
        check("rst_req",     32'(irq_req),     0);
        check("rst_active",  32'(irq_active),  0);
        check("rst_pending", 32'(irq_pending), 0);
        check("rst_id",      32'(irq_id),      0);
        areset = 1'b0;

        // 1: single edge line 3
        irq_edge = 8'hFF;
        irq_en   = 8'hFF;
        irq      = 8'h08;
        tick();
        check("t1_pend", 32'(irq_pending), 32'h08);
        check("t1_req_early", 32'(irq_req), 0);
        tick();
        check_req("t1", 1'b1, 3'd3);
        tick();
        check_req("t1_hold", 1'b1, 3'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t1_active", 32'(irq_active), 1);
        check("t1_req_off", 32'(irq_req), 0);
        check("t1_pend_clr", 32'(irq_pending), 32'h00);
        tick(2);
        check("t1_still_active", 32'(irq_active), 1);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("t1_active_off", 32'(irq_active), 0);
        check("t1_req_idle", 32'(irq_req), 0);
        irq = 8'h00;
        tick();

        // 2: lines 5 and 2 together, lower index first
        irq = 8'h24;
        tick();
        check("t2_pend", 32'(irq_pending), 32'h24);
        tick();
        check_req("t2_first", 1'b1, 3'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_pend_after_ack", 32'(irq_pending), 32'h20);
        check("t2_active", 32'(irq_active), 1);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("t2_idle_gap", 32'(irq_req), 0);
        tick();
        check_req("t2_second", 1'b1, 3'd5);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_pend_empty", 32'(irq_pending), 32'h00);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        irq = 8'h00;
        tick();
        check("t2_no_req", 32'(irq_req), 0);

        // 3: level line 1 withdrawn by the line dropping, then by disabling it
        irq_edge = 8'hFD;
        irq = 8'h02;
        tick();
        check("t3_pend", 32'(irq_pending), 32'h02);
        tick();
        check_req("t3_req", 1'b1, 3'd1);
        irq = 8'h00;
        tick();
        check("t3_pend_drop", 32'(irq_pending), 32'h00);
        check("t3_req_lag", 32'(irq_req), 1);
        tick();
        check("t3_withdrawn", 32'(irq_req), 0);
        check("t3_not_active", 32'(irq_active), 0);
        irq = 8'h02;
        tick(2);
        check_req("t3b_req", 1'b1, 3'd1);
        irq_en = 8'hFD;
        tick(2);
        check("t3b_withdrawn", 32'(irq_req), 0);
        check("t3b_not_active", 32'(irq_active), 0);
        check("t3b_pend_kept", 32'(irq_pending), 32'h02);
        irq_en = 8'hFF;
        tick();
        check_req("t3c_req", 1'b1, 3'd1);
        irq = 8'h00;
        tick(2);
        check("t3c_withdrawn", 32'(irq_req), 0);

        // 4: edge line 0 re-rises in its ack cycle
        irq_edge = 8'hFF;
        irq = 8'h01;
        tick(2);
        check_req("t4_req", 1'b1, 3'd0);
        irq = 8'h00;
        tick();
        check("t4_edge_held", 32'(irq_pending), 32'h01);
        check_req("t4_no_withdraw", 1'b1, 3'd0);
        irq = 8'h01;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t4_set_wins", 32'(irq_pending), 32'h01);
        check("t4_active", 32'(irq_active), 1);
        check("t4_no_nest", 32'(irq_req), 0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        check_req("t4_again", 1'b1, 3'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t4_pend_clr", 32'(irq_pending), 32'h00);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        irq = 8'h00;
        tick();

        // 5: masked pending line never requests; stray ack in IDLE is ignored
        irq_en = 8'hEF;
        irq = 8'h10;
        tick();
        check("t5_pend", 32'(irq_pending), 32'h10);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_ack_ignored", 32'(irq_pending), 32'h10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_masked", 32'(irq_req), 0);
        end
        irq_en = 8'hFF;
        tick();
        check_req("t5_unmasked", 1'b1, 3'd4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        irq = 8'h00;
        tick();
        check("t5_done_idle", 32'(irq_active), 0);

        // 6: reset in SERVICE, level line 7 re-requests after release
        irq_edge = 8'h7E;
        irq = 8'h81;
        tick();
        check("t6_pend", 32'(irq_pending), 32'h81);
        tick();
        check_req("t6_req", 1'b1, 3'd0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check_req("t6_done_ignored", 1'b1, 3'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t6_active", 32'(irq_active), 1);
        check("t6_pend_svc", 32'(irq_pending), 32'h81);
        areset = 1'b1;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("t6_rst_req",     32'(irq_req),     0);
        check("t6_rst_active",  32'(irq_active),  0);
        check("t6_rst_pending", 32'(irq_pending), 0);
        check("t6_rst_id",      32'(irq_id),      0);
        areset = 1'b0;
        irq = 8'h80;
        tick();
        check("t6_pend_post", 32'(irq_pending), 32'h80);
        check("t6_req_lag", 32'(irq_req), 0);
        tick();
        check_req("t6_rereq", 1'b1, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
